// File: rtl/clip_sat_monitor.sv
// Purpose: registered signed saturating clip (bits_in -> bits_out) with windowed clip-event statistics.
// Latency: 1 cycle from stb_in to stb_out/out/clip_now; statistics update on the same edge.
// Backpressure: none; accepts a sample every cycle, stb_in qualifies data and is never stalled.
//
// Ports:
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   clear          synchronous clear of window index, accumulator and sticky flag
//   enable         statistics enable (data path ignores it)
//   stb_in, in     input sample strobe and signed sample
//   stb_out, out   registered strobe and clipped sample
//   clip_now       sample currently on out was saturated
//   clip_sticky    any clip seen while enabled, held until clear
//   clip_count     clip total of the last completed window
//   count_valid    one-cycle pulse when clip_count updates
module clip_sat_monitor #(
  parameter int bits_in     = 18,
  parameter int bits_out    = 16,
  parameter int cnt_width   = 16,
  parameter int window_log2 = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       enable,
  input  logic                       stb_in,
  input  logic signed [bits_in-1:0]  in,
  output logic                       stb_out,
  output logic signed [bits_out-1:0] out,
  output logic                       clip_now,
  output logic                       clip_sticky,
  output logic [cnt_width-1:0]       clip_count,
  output logic                       count_valid
);

  localparam logic signed [bits_out-1:0] max_val = {1'b0, {(bits_out-1){1'b1}}};
  localparam logic signed [bits_out-1:0] min_val = {1'b1, {(bits_out-1){1'b0}}};
  localparam int                         up_w    = bits_in - bits_out + 1;
  localparam logic [window_log2-1:0]     widx_one = {{(window_log2-1){1'b0}}, 1'b1};
  localparam logic [cnt_width-1:0]       acc_one  = {{(cnt_width-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [window_log2-1:0]  widx;
  logic [cnt_width-1:0]    acc;

  // ------------------------------------------------------------------
  // Clip arithmetic
  // ------------------------------------------------------------------
  // The sample fits in bits_out only if every discarded bit equals the
  // new sign bit, i.e. the upper slice is all-zeros or all-ones.
  logic [up_w-1:0]          upper;
  logic                     in_clip;
  logic signed [bits_out-1:0] clip_val;

  assign upper   = in[bits_in-1:bits_out-1];
  assign in_clip = (upper != {up_w{1'b0}}) && (upper != {up_w{1'b1}});

  always_comb begin
    clip_val = in[bits_out-1:0];
    if (in_clip) begin
      clip_val = in[bits_in-1] ? min_val : max_val;
    end
  end

  // ------------------------------------------------------------------
  // Data register: out/clip_now hold between strobes
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_out  <= 1'b0;
      out      <= '0;
      clip_now <= 1'b0;
    end else begin
      stb_out <= stb_in;
      if (stb_in) begin
        out      <= clip_val;
        clip_now <= in_clip;
      end
    end
  end

  // ------------------------------------------------------------------
  // Statistics FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  logic                 count_en;
  logic                 win_end;
  logic [cnt_width-1:0] acc_inc;
  logic [cnt_width-1:0] acc_next;

  always_comb begin
    state_d  = state_q;
    count_en = 1'b0;
    win_end  = 1'b0;
    acc_inc  = acc;
    acc_next = acc;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
        end
        // enable is also required here so a sample arriving on the cycle
        // enable drops is passed through but not counted.
        count_en = enable && stb_in && !clear;
      end
      default: state_d = IDLE;
    endcase
    // Accumulator saturates at all-ones rather than wrapping.
    if (acc != {cnt_width{1'b1}}) begin
      acc_inc = acc + acc_one;
    end
    acc_next = in_clip ? acc_inc : acc;
    win_end  = count_en && (widx == {window_log2{1'b1}});
  end

  // ------------------------------------------------------------------
  // Window index, accumulator, sticky flag, published count
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx        <= '0;
      acc         <= '0;
      clip_sticky <= 1'b0;
      clip_count  <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (clear) begin
        // clear wins over a coincident sample: nothing is counted and no
        // window completes; clip_count keeps the last published value.
        widx        <= '0;
        acc         <= '0;
        clip_sticky <= 1'b0;
      end else begin
        if (enable && stb_in && in_clip) begin
          clip_sticky <= 1'b1;
        end
        if (count_en) begin
          widx <= widx + widx_one;
          if (win_end) begin
            clip_count  <= acc_next;
            count_valid <= 1'b1;
            acc         <= '0;
          end else begin
            acc <= acc_next;
          end
        end
      end
    end
  end

endmodule
